cache_ctrl_fsm: RTL and testbench
=================================

Name: cache_ctrl_fsm

Overview:
- Controller FSM that sits directly upstream of the set-associative `cache_memory` block.
- Accepts single-word CPU read/write requests over a valid/ready handshake.
- Decodes each request into tag/index/offset and sequences the cache enables for hit, clean-miss and dirty-miss (write-back then refill) flows.
- Runs the block-wide main-memory handshake and keeps hit/miss statistics counters.

Parameters:
- ADDR_WIDTH, 32, CPU word-address width.
- WORD_SIZE, 32, data word bits.
- WORDS_PER_BLOCK, 4, words per cache line.
- BLOCK_SIZE, WORDS_PER_BLOCK*WORD_SIZE, line bits.
- NUM_SETS, 32, sets in the attached cache.
- OFFSET_WIDTH, $clog2(WORDS_PER_BLOCK), word-offset bits.
- INDEX_WIDTH, $clog2(NUM_SETS), set-index bits.
- TAG_WIDTH, ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH, tag bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req_valid  in  1  CPU request valid.
- cpu_ready  out  1  controller can accept a request.
- cpu_req_we  in  1  0=read, 1=write.
- cpu_addr  in  ADDR_WIDTH  word address: {tag, index, offset}, offset in the LSBs.
- cpu_wdata  in  WORD_SIZE  write data.
- cpu_resp_valid  out  1  one-cycle response pulse.
- cpu_rdata  out  WORD_SIZE  read data, valid with the response.
- tag  out  TAG_WIDTH  latched request tag to the cache.
- index  out  INDEX_WIDTH  latched request index to the cache.
- blk_offset  out  OFFSET_WIDTH  latched request offset to the cache.
- req_type  out  1  latched request type to the cache.
- data_in  out  WORD_SIZE  latched write word to the cache.
- read_en_cache  out  1  cache read / victim-read strobe.
- write_en_cache  out  1  cache write / refill strobe.
- read_en_mem  out  1  refill strobe.
- write_en_mem  out  1  write-back strobe.
- data_in_mem  out  BLOCK_SIZE  refill line to the cache.
- hit  in  1  cache hit, combinational from the cache.
- dirty_bit  in  1  selected victim is valid and dirty.
- victim_tag  in  TAG_WIDTH  tag of the selected victim line, supplied by the cache.
- dirty_block_out  in  BLOCK_SIZE  registered write-back line from the cache.
- data_out  in  WORD_SIZE  registered read word from the cache.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_WIDTH-OFFSET_WIDTH  memory block address.
- mem_wdata  out  BLOCK_SIZE  write-back line.
- mem_rdata  in  BLOCK_SIZE  refill line from memory.
- mem_ack  in  1  memory completion, one cycle.
- hit_count  out  32  completed hits, saturating.
- miss_count  out  32  misses, saturating.

Behaviour:
- Reset (async): state=IDLE; all request latches, buffers and counters cleared.
  - Every output 0 except cpu_ready=1.
  - Reset in any state drops mem_req immediately; the pending CPU request is discarded with no response.
- States: IDLE, COMPARE, RESPOND, WB_ISSUE, WB_LATCH, WB_WAIT, ALLOCATE, REFILL.
- Enables to the cache are asserted only in the states listed below.
- IDLE:
  - cpu_ready=1.
  - On cpu_req_valid: latch address, we and wdata, then go to COMPARE.
  - cpu_ready=0 in all other states.
- COMPARE:
  - On hit: assert read_en_cache (read) or write_en_cache (write) for this cycle; hit_count++; go to RESPOND.
  - On miss: no enables; miss_count++ only on the first COMPARE of a request (a post-refill COMPARE is not counted as a second miss).
    - dirty_bit=1: go to WB_ISSUE.
    - dirty_bit=0: go to ALLOCATE.
- RESPOND:
  - cpu_resp_valid=1 for exactly one cycle.
  - cpu_rdata = data_out for reads, 0 for writes.
  - Then go to IDLE.
- WB_ISSUE:
  - read_en_cache=1 and write_en_mem=1 for one cycle.
  - Latch wb_addr={victim_tag, index}; go to WB_LATCH.
- WB_LATCH: capture dirty_block_out into wb_buf (the cache clears that output on the next cycle); go to WB_WAIT.
- WB_WAIT:
  - mem_req=1, mem_we=1, mem_addr=wb_addr, mem_wdata=wb_buf, all held stable until mem_ack.
  - On mem_ack: go to ALLOCATE.
- ALLOCATE:
  - mem_req=1, mem_we=0, mem_addr={tag, index}, held until mem_ack.
  - On mem_ack: capture mem_rdata into fill_buf; go to REFILL.
- REFILL:
  - read_en_mem=1 and write_en_cache=1 for one cycle, data_in_mem=fill_buf.
  - Then return to COMPARE, which must now hit.
- Memory handshake:
  - mem_ack is sampled only while mem_req=1; mem_req deasserts the cycle after mem_ack.
  - mem_ack outside WB_WAIT or ALLOCATE is ignored.
- Latency from the accept edge T:
  - Hit: response at T+2.
  - Clean miss: T+4+Ma, where Ma is the ALLOCATE cycles including the ack cycle.
  - Dirty miss: T+6+Mw+Ma, where Mw is the WB_WAIT cycles.
- Counters saturate at 32'hFFFF_FFFF.

Test Plan:
- Reset, fill line 0x40 with a read miss, then read 0x41 -> cache enables idle during reset; for the 0x41 read, read_en_cache pulses in COMPARE, cpu_resp_valid at T+2 with the refilled word; hit_count=1, miss_count=1.
- Clean read miss with mem_ack delayed 3 cycles -> mem_req held exactly 3 cycles with mem_addr = cpu_addr>>OFFSET_WIDTH and stable; one REFILL pulse; response at T+7 with the word from mem_rdata.
- Write hit 0xDEADBEEF, then evict that line with a conflicting read -> WB_ISSUE pulse; WB_WAIT carries mem_we=1, mem_addr={victim_tag, index} and wb_buf containing 0xDEADBEEF; then ALLOCATE and refill; miss_count increments by exactly 1.
- cpu_req_valid held high across a miss -> cpu_ready=0 until RESPOND completes; the second request is accepted only in IDLE.
- Assert rst during WB_WAIT -> mem_req=0 in the same cycle, no cpu_resp_valid, cpu_ready=1, counters=0.
- Preload hit_count to 32'hFFFF_FFFF via force, then issue a hit -> hit_count stays 32'hFFFF_FFFF.

Source files
------------

// File: rtl/cache_ctrl_fsm.sv
// cache_ctrl_fsm: sequences hit, clean-miss and dirty-miss flows for a set-associative cache
module cache_ctrl_fsm #(
  parameter int ADDR_WIDTH      = 32,
  parameter int WORD_SIZE       = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int BLOCK_SIZE      = WORDS_PER_BLOCK*WORD_SIZE,
  parameter int NUM_SETS        = 32,
  parameter int OFFSET_WIDTH    = $clog2(WORDS_PER_BLOCK),
  parameter int INDEX_WIDTH     = $clog2(NUM_SETS),
  parameter int TAG_WIDTH       = ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cpu_req_valid,
  output logic                             cpu_ready,
  input  logic                             cpu_req_we,
  input  logic [ADDR_WIDTH-1:0]            cpu_addr,
  input  logic [WORD_SIZE-1:0]             cpu_wdata,
  output logic                             cpu_resp_valid,
  output logic [WORD_SIZE-1:0]             cpu_rdata,
  output logic [TAG_WIDTH-1:0]             tag,
  output logic [INDEX_WIDTH-1:0]           index,
  output logic [OFFSET_WIDTH-1:0]          blk_offset,
  output logic                             req_type,
  output logic [WORD_SIZE-1:0]             data_in,
  output logic                             read_en_cache,
  output logic                             write_en_cache,
  output logic                             read_en_mem,
  output logic                             write_en_mem,
  output logic [BLOCK_SIZE-1:0]            data_in_mem,
  input  logic                             hit,
  input  logic                             dirty_bit,
  input  logic [TAG_WIDTH-1:0]             victim_tag,
  input  logic [BLOCK_SIZE-1:0]            dirty_block_out,
  input  logic [WORD_SIZE-1:0]             data_out,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-OFFSET_WIDTH-1:0] mem_addr,
  output logic [BLOCK_SIZE-1:0]            mem_wdata,
  input  logic [BLOCK_SIZE-1:0]            mem_rdata,
  input  logic                             mem_ack,
  output logic [31:0]                      hit_count,
  output logic [31:0]                      miss_count
);
  typedef enum logic [2:0] {IDLE, COMPARE, RESPOND, WB_ISSUE, WB_LATCH, WB_WAIT, ALLOCATE, REFILL} state_t;
  state_t r_state, w_next;
  logic [TAG_WIDTH-1:0]              r_tag;
  logic [INDEX_WIDTH-1:0]            r_index;
  logic [OFFSET_WIDTH-1:0]           r_offset;
  logic                              r_we;
  logic [WORD_SIZE-1:0]              r_wdata;
  logic                              r_refilled;
  logic [ADDR_WIDTH-OFFSET_WIDTH-1:0] r_wb_addr;
  logic [BLOCK_SIZE-1:0]             r_wb_buf;
  logic [BLOCK_SIZE-1:0]             r_fill_buf;
  logic [31:0]                       r_hit_count;
  logic [31:0]                       r_miss_count;
  logic                              w_accept;
  logic                              w_cmp_hit;
  logic                              w_hit_evt;
  logic                              w_miss_evt;
  assign w_accept   = r_state == IDLE && cpu_req_valid;
  assign w_cmp_hit  = r_state == COMPARE && hit;
  // a post-refill COMPARE belongs to a request already counted as a miss
  assign w_hit_evt  = w_cmp_hit && !r_refilled;
  assign w_miss_evt = r_state == COMPARE && !hit && !r_refilled;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_tag        <= '0;
      r_index      <= '0;
      r_offset     <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_refilled   <= 1'b0;
      r_wb_addr    <= '0;
      r_wb_buf     <= '0;
      r_fill_buf   <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_tag      <= cpu_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
        r_index    <= cpu_addr[OFFSET_WIDTH +: INDEX_WIDTH];
        r_offset   <= cpu_addr[OFFSET_WIDTH-1:0];
        r_we       <= cpu_req_we;
        r_wdata    <= cpu_wdata;
        r_refilled <= 1'b0;
      end
      if (r_state == REFILL) r_refilled <= 1'b1;
      if (r_state == WB_ISSUE) r_wb_addr <= {victim_tag, r_index};
      if (r_state == WB_LATCH) r_wb_buf <= dirty_block_out;
      if (r_state == ALLOCATE && mem_ack) r_fill_buf <= mem_rdata;
      r_hit_count  <= r_hit_count + 32'(w_hit_evt && r_hit_count != '1);
      r_miss_count <= r_miss_count + 32'(w_miss_evt && r_miss_count != '1);
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = cpu_req_valid ? COMPARE : IDLE;
      COMPARE:  w_next = hit ? RESPOND : (dirty_bit ? WB_ISSUE : ALLOCATE);
      RESPOND:  w_next = IDLE;
      WB_ISSUE: w_next = WB_LATCH;
      WB_LATCH: w_next = WB_WAIT;
      WB_WAIT:  w_next = mem_ack ? ALLOCATE : WB_WAIT;
      ALLOCATE: w_next = mem_ack ? REFILL : ALLOCATE;
      REFILL:   w_next = COMPARE;
    endcase
  end
  assign cpu_ready      = r_state == IDLE;
  assign cpu_resp_valid = r_state == RESPOND;
  assign cpu_rdata      = (r_state == RESPOND && !r_we) ? data_out : '0;
  assign tag            = r_tag;
  assign index          = r_index;
  assign blk_offset     = r_offset;
  assign req_type       = r_we;
  assign data_in        = r_wdata;
  assign read_en_cache  = (w_cmp_hit && !r_we) || r_state == WB_ISSUE;
  assign write_en_cache = (w_cmp_hit && r_we) || r_state == REFILL;
  assign read_en_mem    = r_state == REFILL;
  assign write_en_mem   = r_state == WB_ISSUE;
  assign data_in_mem    = r_state == REFILL ? r_fill_buf : '0;
  assign mem_req        = r_state == WB_WAIT || r_state == ALLOCATE;
  assign mem_we         = r_state == WB_WAIT;
  assign mem_addr       = r_state == WB_WAIT ? r_wb_addr : (r_state == ALLOCATE ? {r_tag, r_index} : '0);
  assign mem_wdata      = r_state == WB_WAIT ? r_wb_buf : '0;
  assign hit_count      = r_hit_count;
  assign miss_count     = r_miss_count;
endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// tb_cache_ctrl_fsm: drives cache_ctrl_fsm against a behavioural cache and memory, scoreboarding responses
module tb_cache_ctrl_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_req_valid = 1'b0, cpu_req_we = 1'b0, cpu_ready, cpu_resp_valid;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
  logic [24:0] tag, victim_tag;
  logic [4:0] index;
  logic [1:0] blk_offset;
  logic req_type, read_en_cache, write_en_cache, read_en_mem, write_en_mem;
  logic [31:0] data_in, data_out;
  logic [127:0] data_in_mem, dirty_block_out, mem_wdata, mem_rdata;
  logic hit, dirty_bit, mem_req, mem_we, mem_ack;
  logic [29:0] mem_addr;
  logic [31:0] hit_count, miss_count;

  cache_ctrl_fsm dut (
    .clk(clk), .rst(rst), .cpu_req_valid(cpu_req_valid), .cpu_ready(cpu_ready),
    .cpu_req_we(cpu_req_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata), .tag(tag), .index(index),
    .blk_offset(blk_offset), .req_type(req_type), .data_in(data_in),
    .read_en_cache(read_en_cache), .write_en_cache(write_en_cache),
    .read_en_mem(read_en_mem), .write_en_mem(write_en_mem), .data_in_mem(data_in_mem),
    .hit(hit), .dirty_bit(dirty_bit), .victim_tag(victim_tag),
    .dirty_block_out(dirty_block_out), .data_out(data_out), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // reference memory image seen by the CPU, and backing store for written-back lines
  logic [31:0]  gold [logic [31:0]];
  logic [127:0] memb [logic [29:0]];
  logic [31:0]  exp_q [$];

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction
  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : pat(a);
  endfunction
  function automatic logic [127:0] blk(input logic [29:0] b);
    logic [127:0] r;
    if (memb.exists(b)) return memb[b];
    for (int k = 0; k < 4; k++) r[k*32 +: 32] = pat({b, 2'(k)});
    return r;
  endfunction

  // behavioural single-way cache with registered read and write-back outputs
  logic [127:0] cl [32];
  logic [24:0]  ct [32];
  logic [31:0]  cv, cd;
  assign hit        = cv[index] && (ct[index] == tag);
  assign dirty_bit  = cv[index] && cd[index];
  assign victim_tag = ct[index];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cv <= '0;
      cd <= '0;
      dirty_block_out <= '0;
      data_out <= '0;
    end else begin
      dirty_block_out <= '0;
      if (read_en_cache && write_en_mem) dirty_block_out <= cl[index];
      else if (read_en_cache) data_out <= cl[index][blk_offset*32 +: 32];
      if (write_en_cache && read_en_mem) begin
        cl[index] <= data_in_mem;
        ct[index] <= tag;
        cv[index] <= 1'b1;
        cd[index] <= 1'b0;
      end else if (write_en_cache) begin
        cl[index][blk_offset*32 +: 32] <= data_in;
        cd[index] <= 1'b1;
      end
    end
  end

  // memory responder: acks on the ack_dly-th cycle of each request
  int ack_dly = 1, mcyc, last_al_cyc;
  logic m_we, rd_ack_prev;
  logic [29:0] m_addr, last_al_addr, last_wb_addr;
  logic [127:0] m_wd, last_wb_data;
  initial begin
    mem_ack = 1'b0; mem_rdata = '0; mcyc = 0; rd_ack_prev = 1'b0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (rd_ack_prev) check("mem_req_drop", 128'(mem_req), 128'(0));
      rd_ack_prev = 1'b0;
      if (rst || !mem_req) mcyc = 0;
      else begin
        if (mcyc == 0) begin
          m_addr = mem_addr; m_we = mem_we; m_wd = mem_wdata;
        end else begin
          check("mem_addr_stable", 128'({mem_we, mem_addr}), 128'({m_we, m_addr}));
          check("mem_wdata_stable", mem_wdata, m_wd);
        end
        mcyc++;
        if (mcyc >= ack_dly) begin
          mem_ack = 1'b1;
          if (m_we) begin
            memb[m_addr] = m_wd; last_wb_addr = m_addr; last_wb_data = m_wd;
          end else begin
            mem_rdata = blk(m_addr); last_al_addr = m_addr; last_al_cyc = mcyc; rd_ack_prev = 1'b1;
          end
          mcyc = 0;
        end
      end
    end
  end

  // response scoreboard and strobe counters
  int n_refill = 0, n_wbi = 0;
  initial forever begin
    @(negedge clk);
    if (read_en_mem) n_refill++;
    if (read_en_cache && write_en_mem) n_wbi++;
    if (!rst && cpu_resp_valid) begin
      if (exp_q.size() == 0) check("spurious_resp", 128'(1), 128'(0));
      else check("rdata", 128'(cpu_rdata), 128'(exp_q.pop_front()));
    end
  end

  task automatic push(input logic we, input logic [31:0] a, input logic [31:0] d);
    if (we) begin
      gold[a] = d;
      exp_q.push_back(32'h0);
    end else exp_q.push_back(gold_rd(a));
  endtask

  task automatic wait_resp(output int k);
    k = 1;
    while (!cpu_resp_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic req(input logic we, input logic [31:0] a, input logic [31:0] d,
                     input int exp_lat, input string name, output logic [1:0] en);
    int k;
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_we = we; cpu_addr = a; cpu_wdata = d;
    push(we, a, d);
    @(posedge clk);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    en = {read_en_cache, write_en_cache};
    wait_resp(k);
    check({name, "_lat"}, 128'(k), 128'(exp_lat));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] en;
    int k, bad, m0, w0, r0;
    repeat (2) @(negedge clk);
    check("rst_outs", 128'({cpu_resp_valid, read_en_cache, write_en_cache, read_en_mem, write_en_mem,
                            mem_req, mem_we, mem_addr, tag, index, blk_offset, req_type, data_in}), 128'(0));
    check("rst_ready", 128'(cpu_ready), 128'(1));
    check("rst_cnt", 128'({hit_count, miss_count}), 128'(0));
    rst = 1'b0;

    req(1'b0, 32'h40, '0, 5, "rd40_miss", en);
    req(1'b0, 32'h41, '0, 2, "rd41_hit", en);
    check("rd41_en", 128'(en), 128'(2'b10));
    check("hit_cnt1", 128'(hit_count), 128'(1));
    check("miss_cnt1", 128'(miss_count), 128'(1));

    ack_dly = 3; r0 = n_refill;
    req(1'b0, 32'h200, '0, 7, "rd200_slow", en);
    check("alloc_cycles", 128'(last_al_cyc), 128'(3));
    check("alloc_addr", 128'(last_al_addr), 128'(32'h200 >> 2));
    check("refill_pulses", 128'(n_refill - r0), 128'(1));

    req(1'b1, 32'h41, 32'hDEAD_BEEF, 2, "wr41_hit", en);
    check("wr41_en", 128'(en), 128'(2'b01));
    ack_dly = 2; m0 = miss_count; w0 = n_wbi;
    req(1'b0, 32'hC1, '0, 10, "rdC1_dirty", en);
    check("wb_issue", 128'(n_wbi - w0), 128'(1));
    check("wb_addr", 128'(last_wb_addr), 128'(30'h10));
    check("wb_data", last_wb_data, {gold_rd(32'h43), gold_rd(32'h42), gold_rd(32'h41), gold_rd(32'h40)});
    check("miss_delta", 128'(miss_count - m0), 128'(1));
    req(1'b0, 32'h41, '0, 6, "rd41_back", en);

    ack_dly = 1;
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_addr = 32'h300;
    push(1'b0, 32'h300, '0);
    @(posedge clk);
    @(negedge clk);
    cpu_addr = 32'h301;
    push(1'b0, 32'h301, '0);
    k = 1; bad = 0;
    while (!cpu_resp_valid && k < 300) begin
      bad += int'(cpu_ready);
      @(negedge clk);
      k++;
    end
    check("hold_lat1", 128'(k), 128'(5));
    check("hold_busy", 128'(bad), 128'(0));
    check("hold_ready_resp", 128'(cpu_ready), 128'(0));
    @(negedge clk);
    check("hold_idle_ready", 128'(cpu_ready), 128'(1));
    @(posedge clk);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    wait_resp(k);
    check("hold_lat2", 128'(k), 128'(2));

    req(1'b1, 32'h2, 32'h1111_2222, 5, "wr2_miss", en);
    ack_dly = 1000;
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_addr = 32'h82;
    @(posedge clk);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    k = 0;
    while (!(mem_req && mem_we) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("wbwait_reached", 128'(mem_req && mem_we), 128'(1));
    rst = 1'b1;
    #1;
    check("rst_memreq", 128'(mem_req), 128'(0));
    check("rst_ready2", 128'(cpu_ready), 128'(1));
    check("rst_cnt2", 128'({hit_count, miss_count}), 128'(0));
    check("rst_noresp", 128'(cpu_resp_valid), 128'(0));
    @(negedge clk);
    check("rst_noresp2", 128'(cpu_resp_valid), 128'(0));
    rst = 1'b0; ack_dly = 1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_noresp", 128'(cpu_resp_valid), 128'(0));
    end

    req(1'b0, 32'h500, '0, 5, "rd500_miss", en);
    @(negedge clk);
    force dut.r_hit_count = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.r_hit_count;
    req(1'b0, 32'h501, '0, 2, "rd501_hit", en);
    check("hit_sat", 128'(hit_count), 128'(32'hFFFF_FFFF));
    check("miss_after_sat", 128'(miss_count), 128'(1));

    repeat (2) @(negedge clk);
    check("sb_empty", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
